// File: rtl/ra_cfg_loader_if.sv
// ra_cfg_loader_if: load-command, beat-stream and config-write bundle for ra_cfg_loader.
`ifndef LCBDDR_CONFIGWIDTH
`define LCBDDR_CONFIGWIDTH 16
`endif
interface ra_cfg_loader_if #(
  parameter int CFGW = `LCBDDR_CONFIGWIDTH,
  parameter int DW   = 4,
  parameter int NCFG = 4,
  parameter int SELW = 2
);
  logic            ld_start;
  logic [SELW-1:0] ld_sel;
  logic            in_vld;
  logic [0:DW-1]   in_dat;
  logic            in_rdy;
  logic            cfg_wr_o;
  logic [0:NCFG-1] cfg_sel;
  logic [0:CFGW-1] cfg_dat;
  logic            busy;
  logic            err;
  modport master (output ld_start, ld_sel, in_vld, in_dat,
                  input  in_rdy, cfg_wr_o, cfg_sel, cfg_dat, busy, err);
  modport slave  (input  ld_start, ld_sel, in_vld, in_dat,
                  output in_rdy, cfg_wr_o, cfg_sel, cfg_dat, busy, err);
endinterface

// File: rtl/ra_cfg_loader.sv
// ra_cfg_loader: assembles a config word from DW-bit beats (MSB end first) and
// commits it with a one-cycle strobe to a one-hot selected config register.
`ifndef LCBDDR_CONFIGWIDTH
`define LCBDDR_CONFIGWIDTH 16
`endif
module ra_cfg_loader #(
  parameter int CFGW = `LCBDDR_CONFIGWIDTH,
  parameter int DW   = 4,
  parameter int NCFG = 4,
  parameter int SELW = 2
) (
  input logic          clk,
  input logic          rst_n,
  ra_cfg_loader_if.slave bus
);
  localparam int NBEATS = (CFGW + DW - 1) / DW;
  localparam int CW     = $clog2(NBEATS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t          state_q;
  logic [SELW-1:0] sel_q;
  logic [CW-1:0]   cnt_q;
  logic [0:CFGW-1] dat_q, dat_d;
  logic [0:NCFG-1] csel_q, onehot_d;
  logic            rdy_q, wr_q, err_q, sel_ok, last;
  assign sel_ok = int'(bus.ld_sel) < NCFG;
  assign last   = cnt_q == CW'(NBEATS - 1);
  // Bits past CFGW on the final beat simply have no destination and drop out.
  always_comb begin
    dat_d = dat_q;
    for (int j = 0; j < CFGW; j++)
      if (j / DW == int'(cnt_q)) dat_d[j] = bus.in_dat[j % DW];
  end
  always_comb begin
    onehot_d = '0;
    for (int i = 0; i < NCFG; i++) onehot_d[i] = int'(sel_q) == i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
      csel_q  <= '0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      csel_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.ld_start) begin
          err_q <= !sel_ok;
          if (sel_ok) begin
            state_q <= LOAD;
            sel_q   <= bus.ld_sel;
            cnt_q   <= '0;
            dat_q   <= '0;
            rdy_q   <= 1'b1;
          end
        end
        // A new ld_start wins over a concurrent beat: the beat is taken but dropped.
        LOAD: if (bus.ld_start) begin
          err_q   <= 1'b1;
          rdy_q   <= sel_ok;
          state_q <= sel_ok ? LOAD : IDLE;
          sel_q   <= sel_ok ? bus.ld_sel : sel_q;
          dat_q   <= sel_ok ? '0 : dat_q;
          cnt_q   <= '0;
        end else if (bus.in_vld) begin
          dat_q <= dat_d;
          if (last) begin
            state_q <= COMMIT;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b1;
            csel_q  <= onehot_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          err_q   <= bus.ld_start;
        end
      endcase
    end
  end
  assign bus.in_rdy   = rdy_q;
  assign bus.cfg_wr_o = wr_q;
  assign bus.cfg_sel  = csel_q;
  assign bus.cfg_dat  = dat_q;
  assign bus.busy     = state_q != IDLE;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_ra_cfg_loader.sv
// tb_ra_cfg_loader: directed bench; a word-level model checks DUT A every cycle,
// literal expectations pin whole transactions and the CFGW=10 instance.
module tb_ra_cfg_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ra_cfg_loader_if #(.CFGW(16), .DW(4), .NCFG(4), .SELW(3)) ia ();
  ra_cfg_loader_if #(.CFGW(10), .DW(4), .NCFG(4), .SELW(2)) ib ();
  ra_cfg_loader #(.CFGW(16), .DW(4), .NCFG(4), .SELW(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  ra_cfg_loader #(.CFGW(10), .DW(4), .NCFG(4), .SELW(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Word-level model of DUT A (CFGW=16, DW=4, NCFG=4): beat k lands in nibble k from the top.
  bit m_loading, m_commit, m_err, pc;
  int m_beats;
  logic [2:0] m_sel;
  logic [15:0] m_word;
  int wr_cnt = 0, busy_cnt = 0, rdy_cnt = 0, err_cnt = 0;
  logic [15:0] last_dat;
  logic [3:0] last_sel;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_loading = 0; m_commit = 0; m_err = 0; m_sel = 0; m_word = 0; m_beats = 0;
    end else begin
      pc = m_commit;
      m_commit = 0;
      m_err = ia.ld_start && (pc || m_loading || ia.ld_sel >= 3'd4);
      if (ia.ld_start && !pc) begin
        m_loading = ia.ld_sel < 3'd4;
        if (m_loading) begin
          m_sel = ia.ld_sel; m_word = 0; m_beats = 0;
        end
      end else if (m_loading && ia.in_vld) begin
        m_word[15-4*m_beats -: 4] = ia.in_dat;
        m_beats++;
        if (m_beats == 4) begin
          m_loading = 0; m_commit = 1;
        end
      end
    end
    #2;
    chk("in_rdy", 32'(ia.in_rdy), 32'(m_loading));
    chk("busy", 32'(ia.busy), 32'(m_loading | m_commit));
    chk("cfg_wr_o", 32'(ia.cfg_wr_o), 32'(m_commit));
    chk("cfg_sel", 32'(ia.cfg_sel), m_commit ? 32'(4'b1000 >> m_sel) : 32'd0);
    chk("cfg_dat", 32'(ia.cfg_dat), 32'(m_word));
    chk("err", 32'(ia.err), 32'(m_err));
    if (ia.cfg_wr_o) begin
      wr_cnt++; last_dat = ia.cfg_dat; last_sel = ia.cfg_sel;
    end
    busy_cnt += int'(ia.busy);
    rdy_cnt += int'(ia.in_rdy);
    err_cnt += int'(ia.err);
  end
  task automatic cyc(input bit ls, input logic [2:0] sel, input bit v, input logic [3:0] d);
    @(negedge clk);
    ia.ld_start = ls; ia.ld_sel = sel; ia.in_vld = v; ia.in_dat = d;
  endtask
  task automatic cycb(input bit ls, input logic [1:0] sel, input bit v, input logic [3:0] d);
    @(negedge clk);
    ib.ld_start = ls; ib.ld_sel = sel; ib.in_vld = v; ib.in_dat = d;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask
  int w0, b0, r0, e0;
  task automatic snap;
    w0 = wr_cnt; b0 = busy_cnt; r0 = rdy_cnt; e0 = err_cnt;
  endtask
  initial begin
    ia.ld_start = 0; ia.ld_sel = 0; ia.in_vld = 0; ia.in_dat = 0;
    ib.ld_start = 0; ib.ld_sel = 0; ib.in_vld = 0; ib.in_dat = 0;
    repeat (2) @(negedge clk);
    chk("reset_dat", 32'(ia.cfg_dat), 32'd0);
    chk("reset_b_busy", 32'(ib.busy), 32'd0);
    rst_n = 1'b1;
    idle(2);
    // 1: back-to-back beats to target 2
    snap();
    cyc(1, 2, 0, 0);
    cyc(0, 0, 1, 4'hA); cyc(0, 0, 1, 4'hB); cyc(0, 0, 1, 4'hC); cyc(0, 0, 1, 4'hD);
    idle(3);
    chk("t1_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t1_dat", 32'(last_dat), 32'hABCD);
    chk("t1_sel", 32'(last_sel), 32'b0010);
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd5);
    // 2: gaps of 0, 3, 1 cycles
    snap();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 4'h1); cyc(0, 0, 1, 4'h2); idle(3);
    cyc(0, 0, 1, 4'h3); idle(1); cyc(0, 0, 1, 4'h4);
    idle(3);
    chk("t2_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t2_dat", 32'(last_dat), 32'h1234);
    chk("t2_sel", 32'(last_sel), 32'b1000);
    chk("t2_rdy_cycles", 32'(rdy_cnt - r0), 32'd8);
    // 3: CFGW=10 drops the low 2 bits of the last beat
    cycb(1, 1, 0, 0);
    cycb(0, 0, 1, 4'hF); cycb(0, 0, 1, 4'h0); cycb(0, 0, 1, 4'hF);
    cycb(0, 0, 0, 0);
    @(posedge clk); #3;
    chk("t3_b_busy_idle", 32'(ib.busy), 32'd0);
    chk("t3_b_dat_partial", 32'(ib.cfg_dat), 32'b1111000011);
    cycb(1, 0, 0, 0);
    cycb(0, 0, 1, 4'hF); cycb(0, 0, 1, 4'h0); cycb(0, 0, 1, 4'hC);
    cycb(0, 0, 0, 0);
    chk("t3_b_wr", 32'(ib.cfg_wr_o), 32'd1);
    chk("t3_b_dat", 32'(ib.cfg_dat), 32'b1111000011);
    chk("t3_b_sel", 32'(ib.cfg_sel), 32'b1000);
    cycb(0, 0, 0, 0);
    chk("t3_b_wr_drop", 32'(ib.cfg_wr_o), 32'd0);
    chk("t3_b_sel_drop", 32'(ib.cfg_sel), 32'd0);
    chk("t3_b_dat_hold", 32'(ib.cfg_dat), 32'b1111000011);
    // 4: restart mid-load with a concurrent beat
    snap();
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 4'h1); cyc(0, 0, 1, 4'h2);
    cyc(1, 3, 1, 4'h9);
    cyc(0, 0, 1, 4'h5); cyc(0, 0, 1, 4'h6); cyc(0, 0, 1, 4'h7); cyc(0, 0, 1, 4'h8);
    idle(3);
    chk("t4_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t4_dat", 32'(last_dat), 32'h5678);
    chk("t4_sel", 32'(last_sel), 32'b0001);
    chk("t4_errs", 32'(err_cnt - e0), 32'd1);
    // 5: out-of-range select from IDLE
    snap();
    cyc(1, 5, 0, 0);
    idle(3);
    chk("t5_errs", 32'(err_cnt - e0), 32'd1);
    chk("t5_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t5_busy", 32'(busy_cnt - b0), 32'd0);
    // 6: reset mid-load, then a clean load
    snap();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 4'h1); cyc(0, 0, 1, 4'h2); cyc(0, 0, 1, 4'h3);
    @(negedge clk);
    ia.in_vld = 0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(ia.busy), 32'd0);
    chk("t6_rst_rdy", 32'(ia.in_rdy), 32'd0);
    chk("t6_rst_dat", 32'(ia.cfg_dat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("t6_no_write", 32'(wr_cnt - w0), 32'd0);
    cyc(1, 3, 0, 0);
    cyc(0, 0, 1, 4'hF); cyc(0, 0, 1, 4'hE); cyc(0, 0, 1, 4'hD); cyc(0, 0, 1, 4'hC);
    idle(3);
    chk("t6_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t6_dat", 32'(last_dat), 32'hFEDC);
    chk("t6_sel", 32'(last_sel), 32'b0001);
    // ld_start during COMMIT: ignored except for err
    snap();
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 4'h9); cyc(0, 0, 1, 4'h8); cyc(0, 0, 1, 4'h7); cyc(0, 0, 1, 4'h6);
    cyc(1, 2, 0, 0);
    idle(3);
    chk("t7_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t7_dat", 32'(last_dat), 32'h9876);
    chk("t7_errs", 32'(err_cnt - e0), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ra_cfg_loader.md
Name: ra_cfg_loader

Overview:
Upstream feeder for the array local config registers. It assembles a config word from a narrow beat stream with a valid/ready handshake, then issues a one-cycle write strobe and the assembled word to one of NCFG config-register instances, selected one-hot. The write strobe and data drive each target's cfg_wr/cfg_dat inputs directly (cfg_wr = cfg_wr_o & cfg_sel[i]).

Parameters:
CFGW, `LCBDDR_CONFIGWIDTH, config word width; must match the target register width.
DW, 4, input beat width; 1 <= DW <= CFGW.
NCFG, 4, number of target config registers.
SELW, 2, target index width; NCFG <= 2^SELW.
NBEATS, (CFGW+DW-1)/DW, derived local beats per word; not overridden.

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ld_start  input  1  begin load of a new word
ld_sel  input  SELW  target index, sampled with ld_start
in_vld  input  1  beat valid
in_dat  input  [0:DW-1]  beat data
in_rdy  output  1  beat ready; a beat transfers when in_vld & in_rdy
cfg_wr_o  output  1  one-cycle write strobe to targets
cfg_sel  output  [0:NCFG-1]  one-hot target select; bit i = target i
cfg_dat  output  [0:CFGW-1]  assembled config word
busy  output  1  state != IDLE
err  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset (reset=0, async): state=IDLE; in_rdy, cfg_wr_o, busy, err = 0; cfg_sel, cfg_dat, beat counter = 0. All outputs are registered or decoded from state only; no combinational input-to-output paths.
- States: IDLE, LOAD, COMMIT.
- IDLE: in_rdy=0. ld_start=1 with ld_sel<NCFG -> LOAD next cycle; latch sel; clear cfg_dat and beat counter. ld_start=1 with ld_sel>=NCFG -> stay IDLE, err=1 next cycle. in_vld without a load in progress is ignored.
- LOAD: in_rdy=1. Beat k (0-based) writes in_dat[0:DW-1] to cfg_dat[k*DW : k*DW+DW-1]. The first beat fills the MSB end (index 0).
- Final beat when CFGW%DW != 0: only in_dat[0:rem-1] is used and the rest is discarded, where rem = CFGW - (NBEATS-1)*DW.
- Gaps (in_vld=0) are allowed for any number of cycles. There is no timeout.
- When beat NBEATS-1 transfers -> COMMIT next cycle; in_rdy drops in that same next cycle.
- COMMIT (exactly 1 cycle): cfg_wr_o=1, cfg_sel=onehot(sel), cfg_dat=final word. Then -> IDLE.
- Latency: cfg_wr_o is high in the cycle after the last beat transfers.
- After COMMIT: cfg_sel returns to 0; cfg_dat holds its value until the next accepted ld_start.
- ld_start during LOAD (valid sel): abort the current word, restart LOAD with the new sel, clear the counter and cfg_dat, err=1 next cycle. A beat presented in the same cycle is accepted on the handshake but discarded. No write is issued for the aborted word.
- ld_start during LOAD (invalid sel): abort -> IDLE, err=1.
- ld_start during COMMIT: ignored, err=1. The commit completes normally.
- Reset asserted mid-LOAD or in COMMIT: immediate return to the reset values. No partial write is issued; cfg_wr_o drops asynchronously.
- Counter width is clog2(NBEATS+1). The counter never wraps past NBEATS-1.

Test Plan:
1. CFGW=16, DW=4, NCFG=4. ld_start with ld_sel=2, then beats A,B,C,D back-to-back -> cfg_wr_o=1 for exactly 1 cycle, the cycle after beat D; cfg_dat=16'hABCD; cfg_sel[0:3]=0,0,1,0; busy=1 for 5 cycles.
2. Same config with in_vld gaps of 0, 3, and 1 cycles between beats 1,2,3,4 = 1,2,3,4 -> cfg_dat=16'h1234; a single write strobe; in_rdy=1 throughout LOAD.
3. CFGW=10, DW=4: beats F,0,C -> cfg_dat=10'b1111000011; the low 2 bits of the last beat are ignored.
4. Load sel=1, 2 beats, then ld_start with ld_sel=3 plus a concurrent beat 9, then beats 5,6,7,8 -> err pulse; one write only, with cfg_sel=0,0,0,1 and cfg_dat=16'h5678.
5. ld_start with ld_sel=5 (NCFG=4, SELW=3) from IDLE -> err=1 for 1 cycle; state stays IDLE; no cfg_wr_o.
6. Drive reset low for 1 cycle after beat 3 of a load -> all outputs are zero during reset, no cfg_wr_o, and the next full load commits correctly.
